rs_syndrome_calc: RTL and testbench

Parametrised Reed-Solomon syndrome generator for the RS decoder front end: it accepts one received symbol per cycle over a valid/ready handshake and evaluates the 2t syndromes S_j = r(alpha^(FCR+j)) by Horner's rule. Results go into a holding bank, so the next codeword can accumulate while downstream stages (Berlekamp-Massey, Forney, error-value paths) read the previous one. It generalises symbol width, code length, syndrome count, first root, field polynomial and read-port count. It adds back-pressure, an all-zero (error-free) flag and explicit bank release.

---
 rtl/rs_pkg.sv | 32 +++
 rtl/rs_gf_cmul.sv | 16 +
 rtl/rs_syndrome_calc.sv | 143 ++++++++++++++
 tb/tb_rs_syndrome_calc.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// Shared GF(2^m) helpers for the Reed-Solomon syndrome front end.
// Symbol widths up to 16 bits are supported by the helper functions.
package rs_pkg;

  localparam int unsigned RS_DEF_POLY = 32'h0000_011D;

  function automatic logic [15:0] gf_mul(input logic [15:0] a, input logic [15:0] b,
                                         input logic [16:0] poly, input int m);
    logic [16:0] acc_v;
    logic [16:0] sh_v;
    acc_v = 17'd0;
    sh_v  = {1'b0, a};
    for (int i = 0; i < 16; i++) begin
      if (i < m) begin
        if (b[i]) acc_v = acc_v ^ sh_v;
        sh_v = sh_v << 1;
        if (sh_v[m]) sh_v = sh_v ^ poly;
      end
    end
    return acc_v[15:0];
  endfunction

  function automatic logic [15:0] gf_alpha_pow(input int k, input logic [16:0] poly, input int m);
    logic [15:0] p_v;
    p_v = 16'd1;
    for (int i = 0; i < k; i++) begin
      p_v = gf_mul(p_v, 16'd2, poly, m);
    end
    return p_v;
  endfunction

endpackage

// File: rtl/rs_gf_cmul.sv
// Constant-coefficient GF(2^m) multiplier; COEF is fixed at elaboration so
// this reduces to a pure XOR network.
module rs_gf_cmul
  import rs_pkg::*;
#(
  parameter int          SYM_W     = 8,
  parameter int unsigned PRIM_POLY = RS_DEF_POLY,
  parameter int unsigned COEF      = 32'd1
) (
  input  logic [SYM_W-1:0] x,
  output logic [SYM_W-1:0] y
);

  assign y = SYM_W'(gf_mul(16'(x), 16'(COEF), 17'(PRIM_POLY), SYM_W));

endmodule

// File: rtl/rs_syndrome_calc.sv
// Reed-Solomon syndrome generator: Horner accumulation per lane into W,
// completed sets parked in holding bank H for multi-port readout.
module rs_syndrome_calc
  import rs_pkg::*;
#(
  parameter int          SYM_W     = 8,
  parameter int          N         = 255,
  parameter int          NSYN      = 32,
  parameter int          FCR       = 1,
  parameter int unsigned PRIM_POLY = RS_DEF_POLY,
  parameter int          NUM_RD    = 3,
  localparam int         AW        = $clog2(NSYN)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SYM_W-1:0]        in_data,
  output logic                    cw_end,
  output logic                    syn_valid,
  output logic                    syn_zero,
  input  logic                    syn_release,
  input  logic [NUM_RD-1:0]       rd_req,
  input  logic [NUM_RD*AW-1:0]    rd_addr,
  output logic [NUM_RD*SYM_W-1:0] rd_data,
  output logic [NUM_RD-1:0]       rd_valid
);

  localparam int            CW       = $clog2(N);
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  logic [SYM_W-1:0]        w_r       [NSYN];
  logic [SYM_W-1:0]        h_r       [NSYN];
  logic [SYM_W-1:0]        w_nxt_s   [NSYN];
  logic [SYM_W-1:0]        prod_s    [NSYN];
  logic [SYM_W-1:0]        upd_s     [NSYN];
  logic [SYM_W-1:0]        rd_sel_s  [NUM_RD];
  logic [CW-1:0]           sym_cnt_r;
  logic [CW-1:0]           sym_cnt_nxt_s;
  logic                    hold_full_r;
  logic                    hold_nxt_s;
  logic                    in_ready_r;
  logic                    cw_end_r;
  logic                    syn_zero_r;
  logic                    accept_s;
  logic                    load_s;
  logic                    upd_any_s;
  logic [NUM_RD*SYM_W-1:0] rd_data_r;
  logic [NUM_RD-1:0]       rd_valid_r;

  for (genvar j = 0; j < NSYN; j++) begin : g_lane
    rs_gf_cmul #(
      .SYM_W    (SYM_W),
      .PRIM_POLY(PRIM_POLY),
      .COEF     (32'(gf_alpha_pow(FCR + j, 17'(PRIM_POLY), SYM_W)))
    ) u_cmul (
      .x(w_r[j]),
      .y(prod_s[j])
    );
    assign upd_s[j] = prod_s[j] ^ in_data;
  end

  // Next-state for accumulators, symbol counter and bank occupancy.
  always_comb begin
    accept_s  = in_valid && in_ready_r;
    load_s    = accept_s && (sym_cnt_r == LAST_CNT);
    upd_any_s = 1'b0;
    for (int j = 0; j < NSYN; j++) begin
      upd_any_s  = upd_any_s | (|upd_s[j]);
      w_nxt_s[j] = w_r[j];
    end
    if (load_s) begin
      // The final symbol's result bypasses W straight into H.
      for (int j = 0; j < NSYN; j++) w_nxt_s[j] = {SYM_W{1'b0}};
      sym_cnt_nxt_s = {CW{1'b0}};
    end else if (accept_s) begin
      for (int j = 0; j < NSYN; j++) w_nxt_s[j] = upd_s[j];
      sym_cnt_nxt_s = sym_cnt_r + CW'(1);
    end else begin
      sym_cnt_nxt_s = sym_cnt_r;
    end
    if (load_s) begin
      hold_nxt_s = 1'b1;
    end else if (syn_release) begin
      hold_nxt_s = 1'b0;
    end else begin
      hold_nxt_s = hold_full_r;
    end
  end

  // Read-port muxes; addresses beyond the last syndrome match nothing and yield zero.
  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      rd_sel_s[p] = {SYM_W{1'b0}};
      for (int j = 0; j < NSYN; j++) begin
        rd_sel_s[p] = (rd_addr[p*AW +: AW] == AW'(j)) ? h_r[j] : rd_sel_s[p];
      end
    end
  end

  // State registers and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int j = 0; j < NSYN; j++) begin
        w_r[j] <= {SYM_W{1'b0}};
        h_r[j] <= {SYM_W{1'b0}};
      end
      sym_cnt_r   <= {CW{1'b0}};
      hold_full_r <= 1'b0;
      in_ready_r  <= 1'b1;
      cw_end_r    <= 1'b0;
      syn_zero_r  <= 1'b0;
      rd_data_r   <= {(NUM_RD*SYM_W){1'b0}};
      rd_valid_r  <= {NUM_RD{1'b0}};
    end else begin
      for (int j = 0; j < NSYN; j++) w_r[j] <= w_nxt_s[j];
      sym_cnt_r   <= sym_cnt_nxt_s;
      hold_full_r <= hold_nxt_s;
      in_ready_r  <= !(hold_nxt_s && (sym_cnt_nxt_s == LAST_CNT));
      cw_end_r    <= load_s;
      if (load_s) begin
        for (int j = 0; j < NSYN; j++) h_r[j] <= upd_s[j];
        syn_zero_r <= !upd_any_s;
      end
      for (int p = 0; p < NUM_RD; p++) begin
        if (rd_req[p]) begin
          rd_data_r[p*SYM_W +: SYM_W] <= rd_sel_s[p];
          rd_valid_r[p]               <= 1'b1;
        end else begin
          rd_valid_r[p] <= 1'b0;
        end
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign cw_end    = cw_end_r;
  assign syn_valid = hold_full_r;
  assign syn_zero  = syn_zero_r;
  assign rd_data   = rd_data_r;
  assign rd_valid  = rd_valid_r;

endmodule

// File: tb/tb_rs_syndrome_calc.sv
// Bench for rs_syndrome_calc: default-parameter instance plus two small-field
// instances, checked each cycle against a direct polynomial-evaluation model.
module tb_rs_syndrome_calc;

  logic        clock;
  logic        reset;
  logic        iv0, rel0, ir0, ce0, sv0, sz0;
  logic [7:0]  dat0;
  logic [2:0]  rq0, rv0;
  logic [14:0] ra0;
  logic [23:0] rd0;
  logic        iv1, rel1, rq4, rq5;
  logic [3:0]  dat1, rd4, rd5;
  logic [1:0]  ra4;
  logic [2:0]  ra5;
  logic        ir4, ce4, sv4, sz4, rv4, ir5, ce5, sv5, sz5, rv5;

  rs_syndrome_calc u_dut (
    .clock(clock), .reset(reset), .in_valid(iv0), .in_ready(ir0), .in_data(dat0),
    .cw_end(ce0), .syn_valid(sv0), .syn_zero(sz0), .syn_release(rel0),
    .rd_req(rq0), .rd_addr(ra0), .rd_data(rd0), .rd_valid(rv0)
  );

  rs_syndrome_calc #(.SYM_W(4), .N(15), .NSYN(4), .FCR(0), .PRIM_POLY(32'h13), .NUM_RD(1)) u_small4 (
    .clock(clock), .reset(reset), .in_valid(iv1), .in_ready(ir4), .in_data(dat1),
    .cw_end(ce4), .syn_valid(sv4), .syn_zero(sz4), .syn_release(rel1),
    .rd_req(rq4), .rd_addr(ra4), .rd_data(rd4), .rd_valid(rv4)
  );

  rs_syndrome_calc #(.SYM_W(4), .N(15), .NSYN(5), .FCR(0), .PRIM_POLY(32'h13), .NUM_RD(1)) u_small5 (
    .clock(clock), .reset(reset), .in_valid(iv1), .in_ready(ir5), .in_data(dat1),
    .cw_end(ce5), .syn_valid(sv5), .syn_zero(sz5), .syn_release(rel1),
    .rd_req(rq5), .rd_addr(ra5), .rd_data(rd5), .rd_valid(rv5)
  );

  always #5 clock = ~clock;

  // Model state: field 0 = GF(256)/0x11D, field 1 = GF(16)/0x13.
  int exp_t [2][256];
  int log_t [2][256];
  int ord_t [2];
  int cw    [2][256];
  int cnt   [2];
  int mh    [2][32];
  bit mhold [2];
  bit mready[2];
  bit mcw   [2];
  bit macc  [2];
  bit mz    [3];
  int mrd0  [3];
  bit mrv0  [3];
  int mrd4, mrd5;
  bit mrv4, mrv5;
  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic build(input int f, input int m, input int poly);
    int x;
    x = 1;
    ord_t[f] = (1 << m) - 1;
    for (int e = 0; e < ord_t[f]; e++) begin
      exp_t[f][e] = x;
      log_t[f][x] = e;
      x = x << 1;
      if ((x & (1 << m)) != 0) x = x ^ poly;
    end
  endtask

  function automatic int gmul(input int f, input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return exp_t[f][(log_t[f][a] + log_t[f][b]) % ord_t[f]];
  endfunction

  // S_j = sum_i r_i * alpha^((fcr+j)*(n-1-i)), evaluated directly.
  task automatic calc(input int f, input int n, input int fcr, input int ns);
    int s;
    for (int j = 0; j < ns; j++) begin
      s = 0;
      for (int i = 0; i < n; i++)
        s = s ^ gmul(f, cw[f][i], exp_t[f][((fcr + j) * (n - 1 - i)) % ord_t[f]]);
      mh[f][j] = s;
    end
    if (f == 0) begin
      mz[0] = 1'b1;
      for (int j = 0; j < 32; j++) if (mh[0][j] != 0) mz[0] = 1'b0;
    end else begin
      mz[1] = (mh[1][0] | mh[1][1] | mh[1][2] | mh[1][3]) == 0;
      mz[2] = mz[1] && (mh[1][4] == 0);
    end
  endtask

  task automatic core(input int f, input int n, input int fcr, input int ns,
                      input bit iv, input int d, input bit rel);
    bit rel_v, load_v;
    rel_v   = rel && mhold[f];
    load_v  = 1'b0;
    macc[f] = iv && mready[f];
    mcw[f]  = 1'b0;
    if (macc[f]) begin
      cw[f][cnt[f]] = d;
      cnt[f]++;
      if (cnt[f] == n) begin
        calc(f, n, fcr, ns);
        cnt[f] = 0;
        load_v = 1'b1;
      end
    end
    if (load_v) begin
      mhold[f] = 1'b1;
      mcw[f]   = 1'b1;
    end else if (rel_v) begin
      mhold[f] = 1'b0;
    end
    mready[f] = !(mhold[f] && cnt[f] == n - 1);
  endtask

  task automatic model_reset();
    for (int f = 0; f < 2; f++) begin
      cnt[f] = 0; mhold[f] = 1'b0; mready[f] = 1'b1; mcw[f] = 1'b0; macc[f] = 1'b0;
      for (int j = 0; j < 32; j++) mh[f][j] = 0;
    end
    for (int k = 0; k < 3; k++) begin mz[k] = 1'b0; mrd0[k] = 0; mrv0[k] = 1'b0; end
    mrd4 = 0; mrd5 = 0; mrv4 = 1'b0; mrv5 = 1'b0;
  endtask

  task automatic tick();
    int a;
    @(posedge clock);
    if (reset) begin
      model_reset();
    end else begin
      for (int p = 0; p < 3; p++) begin
        mrv0[p] = rq0[p];
        a = int'(ra0[p*5 +: 5]);
        if (rq0[p]) mrd0[p] = (a < 32) ? mh[0][a] : 0;
      end
      mrv4 = rq4;
      if (rq4) mrd4 = mh[1][int'(ra4)];
      mrv5 = rq5;
      if (rq5) mrd5 = (int'(ra5) < 5) ? mh[1][int'(ra5)] : 0;
      core(0, 255, 1, 32, iv0, int'(dat0), rel0);
      core(1, 15, 0, 5, iv1, int'(dat1), rel1);
    end
    #2;
  endtask

  // Every-cycle comparison of all DUT outputs against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      chk("in_ready0", int'(ir0), int'(mready[0]));
      chk("cw_end0", int'(ce0), int'(mcw[0]));
      chk("syn_valid0", int'(sv0), int'(mhold[0]));
      if (mhold[0]) chk("syn_zero0", int'(sz0), int'(mz[0]));
      for (int p = 0; p < 3; p++) begin
        chk($sformatf("rd_valid0_p%0d", p), int'(rv0[p]), int'(mrv0[p]));
        chk($sformatf("rd_data0_p%0d", p), int'(rd0[p*8 +: 8]), mrd0[p]);
      end
      chk("in_ready4", int'(ir4), int'(mready[1]));
      chk("cw_end4", int'(ce4), int'(mcw[1]));
      chk("syn_valid4", int'(sv4), int'(mhold[1]));
      if (mhold[1]) chk("syn_zero4", int'(sz4), int'(mz[1]));
      chk("rd_valid4", int'(rv4), int'(mrv4));
      chk("rd_data4", int'(rd4), mrd4);
      chk("in_ready5", int'(ir5), int'(mready[1]));
      chk("cw_end5", int'(ce5), int'(mcw[1]));
      chk("syn_valid5", int'(sv5), int'(mhold[1]));
      if (mhold[1]) chk("syn_zero5", int'(sz5), int'(mz[2]));
      chk("rd_valid5", int'(rv5), int'(mrv5));
      chk("rd_data5", int'(rd5), mrd5);
    end
  end

  task automatic send0(input int d);
    iv0 = 1'b1;
    dat0 = 8'(d);
    for (int k = 0; k < 8; k++) begin
      tick();
      if (macc[0]) break;
    end
    if (!macc[0]) begin
      checks++; failures++;
      $display("FAIL send0_accept actual=stalled expected=accepted");
    end
    iv0 = 1'b0;
  endtask

  task automatic send1(input int d);
    iv1 = 1'b1;
    dat1 = 4'(d);
    for (int k = 0; k < 8; k++) begin
      tick();
      if (macc[1]) break;
    end
    if (!macc[1]) begin
      checks++; failures++;
      $display("FAIL send1_accept actual=stalled expected=accepted");
    end
    iv1 = 1'b0;
  endtask

  task automatic word0(input int pos, input int val);
    for (int i = 0; i < 255; i++) send0((i == pos) ? val : 0);
  endtask

  task automatic rd3(input int a0, input int a1, input int a2);
    rq0 = 3'b111;
    ra0 = {5'(a2), 5'(a1), 5'(a0)};
    tick();
    rq0 = 3'b000;
  endtask

  task automatic rd1(input int a4, input int a5);
    rq4 = 1'b1; ra4 = 2'(a4);
    rq5 = 1'b1; ra5 = 3'(a5);
    tick();
    rq4 = 1'b0; rq5 = 1'b0;
  endtask

  task automatic lit0(input int p, input int v);
    chk($sformatf("lit_rd0_p%0d", p), int'(rd0[p*8 +: 8]), v);
    chk($sformatf("lit_rv0_p%0d", p), int'(rv0[p]), 1);
  endtask

  task automatic release0();
    rel0 = 1'b1; tick(); rel0 = 1'b0;
  endtask

  task automatic release1();
    rel1 = 1'b1; tick(); rel1 = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    clock = 1'b0; reset = 1'b1;
    iv0 = 1'b0; dat0 = 8'd0; rel0 = 1'b0; rq0 = 3'd0; ra0 = 15'd0;
    iv1 = 1'b0; dat1 = 4'd0; rel1 = 1'b0; rq4 = 1'b0; ra4 = 2'd0; rq5 = 1'b0; ra5 = 3'd0;
    build(0, 8, 32'h11D);
    build(1, 4, 32'h13);
    model_reset();
    chk("model_alpha6", exp_t[0][6], 64);
    chk("model_alpha8", exp_t[0][8], 29);
    chk("model_alpha25", exp_t[0][25], 3);
    chk("model_alpha30", exp_t[0][30], 96);
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    chk("reset_in_ready", int'(ir0), 1);
    chk("reset_syn_valid", int'(sv0), 0);
    chk("reset_cw_end", int'(ce0), 0);
    chk("reset_rd_valid", int'(rv0), 0);
    chk("reset_rd_data", int'(rd0 == 24'd0), 1);

    // All-zero codeword.
    word0(-1, 0);
    chk("zero_cw_end", int'(ce0), 1);
    chk("zero_syn_valid", int'(sv0), 1);
    chk("zero_syn_zero", int'(sz0), 1);
    for (int a = 0; a < 32; a += 3) begin
      rd3(a, (a + 1) % 32, (a + 2) % 32);
      for (int p = 0; p < 3; p++) lit0(p, 0);
    end
    release0();
    chk("release_clears_valid", int'(sv0), 0);

    // Only the last symbol set: every syndrome equals 1.
    word0(254, 1);
    chk("last1_syn_zero", int'(sz0), 0);
    rd3(0, 13, 31);
    for (int p = 0; p < 3; p++) lit0(p, 1);
    release0();

    // Only the second-to-last symbol set: S_j = alpha^(1+j).
    word0(253, 1);
    chk("model_h7", mh[0][7], 29);
    rd3(0, 1, 7);
    lit0(0, 2); lit0(1, 4); lit0(2, 29);
    rd3(24, 29, 5);
    lit0(0, 3); lit0(1, 96); lit0(2, 64);
    rd3(5, 5, 5);
    for (int p = 0; p < 3; p++) lit0(p, 64);

    // Back-to-back word without release stalls on its final symbol.
    send0(7);
    for (int i = 1; i < 254; i++) send0(0);
    iv0 = 1'b1; dat0 = 8'd0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_in_ready", int'(ir0), 0);
    end
    rel0 = 1'b1;
    tick();
    rel0 = 1'b0;
    chk("post_release_ready", int'(ir0), 1);
    tick();
    iv0 = 1'b0;
    chk("b2b_cw_end", int'(ce0), 1);
    chk("b2b_syn_valid", int'(sv0), 1);
    rd3(0, 1, 2);
    lit0(0, 141);
    release0();

    // Reset mid-codeword, then a clean single-error word.
    for (int i = 0; i < 100; i++) send0(int'($urandom_range(0, 255)));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rd3(0, 1, 31);
    lit0(0, 0); lit0(2, 0);
    chk("reset_mid_syn_valid", int'(sv0), 0);
    word0(37, 32'h5A);
    for (int a = 0; a < 32; a += 3) rd3(a, (a + 1) % 32, (a + 2) % 32);
    release0();
    release0();

    // Small field: last symbol = 1, plus out-of-range reads on the NSYN=5 copy.
    for (int i = 0; i < 15; i++) send1((i == 14) ? 1 : 0);
    rd1(2, 6);
    chk("small_lit_rd4", int'(rd4), 1);
    chk("small_oor_rd5", int'(rd5), 0);
    chk("small_oor_rv5", int'(rv5), 1);
    rd1(3, 4);
    chk("small_lit_rd4b", int'(rd4), 1);
    chk("small_lit_rd5b", int'(rd5), 1);
    release1();

    // Small field: random codewords with gaps.
    for (int w = 0; w < 4; w++) begin
      for (int i = 0; i < 15; i++) begin
        if ($urandom_range(0, 3) == 0) tick();
        send1(int'($urandom_range(0, 15)));
      end
      for (int a = 0; a < 8; a++) rd1(a % 4, a);
      release1();
    end
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
